// File: rtl/sa_xaddr_arbiter_pkg.sv
// Shared helpers for the per-slave AW/AR arbiter: index-width derivation and
// the wrap-around increment used by the round-robin pointer and FIFO pointers.
package sa_xaddr_arbiter_pkg;

    // Width needed to index n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Next index after idx in a ring of amt entries (amt-1 wraps to 0).
    function automatic int rr_next(input int idx, input int amt);
        return (idx >= amt - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sa_xaddr_arbiter_rr.sv
// Round-robin grant generator: one-hot grant to the first requester found at
// or after the pointer, pointer moves past the winner when the grant is taken.
module sa_xaddr_arbiter_rr
    import sa_xaddr_arbiter_pkg::*;
#(
    parameter int MST_AMT  = 2,
    parameter int MST_ID_W = clog2_min1(MST_AMT)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [MST_AMT-1:0]  req_i,
    input  logic                en_i,
    output logic [MST_AMT-1:0]  gnt_o,
    output logic [MST_ID_W-1:0] gnt_idx_o,
    output logic                gnt_vld_o
);

    logic [MST_ID_W-1:0]  rr_ptr_q;
    logic [MST_ID_W-1:0]  rr_ptr_d;
    logic [2*MST_AMT-1:0] req_dbl_s;
    logic [MST_AMT-1:0]   req_rot_s;
    logic                 found_s;
    logic [MST_ID_W-1:0]  pick_s;
    int                   sum_s;

    // Rotate requests so the pointer position is bit 0, then take the first set bit.
    always_comb begin
        req_dbl_s = {req_i, req_i} >> rr_ptr_q;
        req_rot_s = req_dbl_s[MST_AMT-1:0];
        found_s   = 1'b0;
        pick_s    = '0;
        sum_s     = 0;
        for (int i = 0; i < MST_AMT; i++) begin
            if (!found_s && req_rot_s[i]) begin
                found_s = 1'b1;
                sum_s   = int'(rr_ptr_q) + i;
                pick_s  = MST_ID_W'((sum_s >= MST_AMT) ? (sum_s - MST_AMT) : sum_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    // One-hot grant and pointer advance, gated by the caller's enable.
    always_comb begin
        gnt_vld_o = en_i & found_s;
        gnt_idx_o = pick_s;
        for (int j = 0; j < MST_AMT; j++) begin
            gnt_o[j] = gnt_vld_o & (pick_s == MST_ID_W'(j));
        end
        if (gnt_vld_o) begin
            rr_ptr_d = MST_ID_W'(rr_next(int'(pick_s), MST_AMT));
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/sa_xaddr_arbiter.sv
// Per-slave AW/AR arbiter: round-robin selects a master dispatcher, registers
// its address beat into a one-stage slice toward the slave and records the
// granted master index in an order FIFO for the slave-side data path.
module sa_xaddr_arbiter
    import sa_xaddr_arbiter_pkg::*;
#(
    parameter int MST_AMT           = 2,
    parameter int OUTSTANDING_AMT   = 8,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int TRANS_BURST_W     = 2,
    parameter int TRANS_DATA_LEN_W  = 3,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter int MST_ID_W          = clog2_min1(MST_AMT),
    parameter int CNT_W             = $clog2(OUTSTANDING_AMT) + 1
) (
    input  logic                                  ACLK_i,
    input  logic                                  ARESET_i,
    input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_AxID_i,
    input  logic [ADDR_WIDTH*MST_AMT-1:0]         dsp_AxADDR_i,
    input  logic [TRANS_BURST_W*MST_AMT-1:0]      dsp_AxBURST_i,
    input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   dsp_AxLEN_i,
    input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]  dsp_AxSIZE_i,
    input  logic [MST_AMT-1:0]                    dsp_AxVALID_i,
    output logic [MST_AMT-1:0]                    dsp_AxREADY_o,
    output logic [MST_ID_W+TRANS_MST_ID_W-1:0]    s_AxID_o,
    output logic [ADDR_WIDTH-1:0]                 s_AxADDR_o,
    output logic [TRANS_BURST_W-1:0]              s_AxBURST_o,
    output logic [TRANS_DATA_LEN_W-1:0]           s_AxLEN_o,
    output logic [TRANS_DATA_SIZE_W-1:0]          s_AxSIZE_o,
    output logic                                  s_AxVALID_o,
    input  logic                                  s_AxREADY_i,
    output logic [MST_ID_W-1:0]                   xDATA_mst_id_o,
    output logic                                  xDATA_valid_o,
    input  logic                                  xDATA_pop_i,
    output logic [CNT_W-1:0]                      outst_ctn_o
);

    localparam int PTR_W = clog2_min1(OUTSTANDING_AMT);

    // Output slice registers
    logic [MST_ID_W+TRANS_MST_ID_W-1:0] s_id_q;
    logic [ADDR_WIDTH-1:0]              s_addr_q;
    logic [TRANS_BURST_W-1:0]           s_burst_q;
    logic [TRANS_DATA_LEN_W-1:0]        s_len_q;
    logic [TRANS_DATA_SIZE_W-1:0]       s_size_q;
    logic                               s_valid_q;

    // Order FIFO state
    logic [MST_ID_W-1:0] fifo_mem_q [OUTSTANDING_AMT];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                     slot_free_s;
    logic                     fifo_full_s;
    logic                     fifo_empty_s;
    logic                     grant_s;
    logic                     pop_s;
    logic [MST_ID_W-1:0]      gnt_idx_s;
    logic [TRANS_MST_ID_W-1:0]    sel_id_s;
    logic [ADDR_WIDTH-1:0]        sel_addr_s;
    logic [TRANS_BURST_W-1:0]     sel_burst_s;
    logic [TRANS_DATA_LEN_W-1:0]  sel_len_s;
    logic [TRANS_DATA_SIZE_W-1:0] sel_size_s;

    // Grant is allowed only when the slice can take a beat and the FIFO has room;
    // a same-cycle pop does not free a slot, so there is no pop->ready path.
    always_comb begin
        slot_free_s  = ~s_valid_q | s_AxREADY_i;
        fifo_full_s  = (cnt_q == CNT_W'(OUTSTANDING_AMT));
        fifo_empty_s = (cnt_q == {CNT_W{1'b0}});
        pop_s        = xDATA_pop_i & ~fifo_empty_s;
    end

    sa_xaddr_arbiter_rr #(
        .MST_AMT  (MST_AMT),
        .MST_ID_W (MST_ID_W)
    ) u_rr (
        .clk_i     (ACLK_i),
        .rst_i     (ARESET_i),
        .req_i     (dsp_AxVALID_i),
        .en_i      (slot_free_s & ~fifo_full_s),
        .gnt_o     (dsp_AxREADY_o),
        .gnt_idx_o (gnt_idx_s),
        .gnt_vld_o (grant_s)
    );

    // Select the granted master's fields out of the packed dispatcher buses.
    always_comb begin
        sel_id_s    = '0;
        sel_addr_s  = '0;
        sel_burst_s = '0;
        sel_len_s   = '0;
        sel_size_s  = '0;
        for (int j = 0; j < MST_AMT; j++) begin
            if (gnt_idx_s == MST_ID_W'(j)) begin
                sel_id_s    = dsp_AxID_i[j*TRANS_MST_ID_W +: TRANS_MST_ID_W];
                sel_addr_s  = dsp_AxADDR_i[j*ADDR_WIDTH +: ADDR_WIDTH];
                sel_burst_s = dsp_AxBURST_i[j*TRANS_BURST_W +: TRANS_BURST_W];
                sel_len_s   = dsp_AxLEN_i[j*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
                sel_size_s  = dsp_AxSIZE_i[j*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
            end else begin
                sel_id_s    = sel_id_s;
            end
        end
    end

    // Output slice: load on grant, drop valid once the slave takes the beat.
    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
            s_id_q    <= '0;
            s_addr_q  <= '0;
            s_burst_q <= '0;
            s_len_q   <= '0;
            s_size_q  <= '0;
            s_valid_q <= 1'b0;
        end else if (grant_s) begin
            s_id_q    <= {gnt_idx_s, sel_id_s};
            s_addr_q  <= sel_addr_s;
            s_burst_q <= sel_burst_s;
            s_len_q   <= sel_len_s;
            s_size_q  <= sel_size_s;
            s_valid_q <= 1'b1;
        end else if (s_AxREADY_i) begin
            s_valid_q <= 1'b0;
        end else begin
            s_valid_q <= s_valid_q;
        end
    end

    // Order FIFO of granted master indices, consumed by the data path.
    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
            for (int i = 0; i < OUTSTANDING_AMT; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (grant_s) begin
                fifo_mem_q[wr_ptr_q] <= gnt_idx_s;
                wr_ptr_q <= PTR_W'(rr_next(int'(wr_ptr_q), OUTSTANDING_AMT));
            end
            if (pop_s) begin
                rd_ptr_q <= PTR_W'(rr_next(int'(rd_ptr_q), OUTSTANDING_AMT));
            end
            case ({grant_s, pop_s})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign s_AxID_o       = s_id_q;
    assign s_AxADDR_o     = s_addr_q;
    assign s_AxBURST_o    = s_burst_q;
    assign s_AxLEN_o      = s_len_q;
    assign s_AxSIZE_o     = s_size_q;
    assign s_AxVALID_o    = s_valid_q;
    assign xDATA_mst_id_o = fifo_mem_q[rd_ptr_q];
    assign xDATA_valid_o  = ~fifo_empty_s;
    assign outst_ctn_o    = cnt_q;

endmodule
